// File: rtl/lpbk_csr_sequencer.sv
// rtl/lpbk_csr_sequencer.sv - CSR initiator that enables serial loopback and polls for PHY lock.
// Optional timeout logic is built only when LPBK_SEQ_TIMEOUT_EN is defined.
module lpbk_csr_sequencer #(
    parameter logic [3:0]  CTRL_ADDR     = 4'h0,
    parameter logic [3:0]  STAT_ADDR     = 4'h1,
    parameter logic [31:0] STAT_MASK     = 32'h3,
    parameter int unsigned POLL_GAP      = 16,
    parameter int unsigned TIMEOUT_POLLS = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        lpbk_en,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] status_last,
    output logic [3:0]  csr_address,
    output logic        csr_read,
    output logic        csr_write,
    output logic [31:0] csr_writedata,
    input  logic [31:0] csr_readdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CAPTURE,
        S_GAP,
        S_FINISH
    } state_t;

    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    state_t      state_q, state_d;
    logic        lpbk_q, lpbk_d;
    logic        pass_q, pass_d;
    logic [31:0] status_q, status_d;
    logic [15:0] poll_q, poll_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] poll_inc;
    logic        mask_ok;

`ifdef LPBK_SEQ_TIMEOUT_EN
    localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_POLLS);
    logic        timeout_q, timeout_d;
`endif

    // Poll counter saturates so a very long lock wait never wraps back to zero.
    assign poll_inc = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
    assign mask_ok  = ((csr_readdata & STAT_MASK) == STAT_MASK);

    always_comb begin
        state_d  = state_q;
        lpbk_d   = lpbk_q;
        pass_d   = pass_q;
        status_d = status_q;
        poll_d   = poll_q;
        gap_d    = gap_q;
`ifdef LPBK_SEQ_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lpbk_d  = lpbk_en;
                    pass_d  = 1'b0;
                    poll_d  = 16'd0;
`ifdef LPBK_SEQ_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_READ;
            S_READ:  state_d = S_CAPTURE;
            S_CAPTURE: begin
                status_d = csr_readdata;
                if (mask_ok) begin
                    pass_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    poll_d  = poll_inc;
                    gap_d   = 16'd0;
                    state_d = S_GAP;
`ifdef LPBK_SEQ_TIMEOUT_EN
                    if (({1'b0, poll_q} + 17'd1) >= TO_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = S_FINISH;
                    end
`endif
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_READ;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            lpbk_q   <= 1'b0;
            pass_q   <= 1'b0;
            status_q <= 32'h0;
            poll_q   <= 16'd0;
            gap_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            lpbk_q   <= lpbk_d;
            pass_q   <= pass_d;
            status_q <= status_d;
            poll_q   <= poll_d;
            gap_q    <= gap_d;
        end
    end

`ifdef LPBK_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Strobes decode straight from state so reset kills an in-flight access at once.
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FINISH);
    assign csr_write     = (state_q == S_WRITE);
    assign csr_read      = (state_q == S_READ);
    assign csr_address   = csr_write ? CTRL_ADDR : (csr_read ? STAT_ADDR : 4'h0);
    assign csr_writedata = csr_write ? {31'b0, lpbk_q} : 32'h0;
    assign pass          = pass_q;
    assign status_last   = status_q;

endmodule

// File: tb/tb_lpbk_csr_sequencer.sv
// tb/tb_lpbk_csr_sequencer.sv - Self-checking bench for lpbk_csr_sequencer.
module tb_lpbk_csr_sequencer;

    localparam int          GAP    = 4;
    localparam int          TPOLLS = 5;
    localparam logic [31:0] MASK   = 32'h3;
    localparam logic [3:0]  CTRL   = 4'h0;
    localparam logic [3:0]  STAT   = 4'h1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        lpbk_en;
    logic        busy, done, pass, timeout;
    logic [31:0] status_last;
    logic [3:0]  csr_address;
    logic        csr_read, csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] stat_vals [0:63];
    int          nstat;
    int          rd_idx;

    typedef struct {
        bit          lp;
        int          nfail;
        logic [31:0] fail_v;
        logic [31:0] pass_v;
        int          inject;
        int          exp_reads;
        bit          exp_pass;
        bit          exp_to;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs [0:5];
    int   n_vec;

    lpbk_csr_sequencer #(
        .CTRL_ADDR(CTRL), .STAT_ADDR(STAT), .STAT_MASK(MASK),
        .POLL_GAP(GAP), .TIMEOUT_POLLS(TPOLLS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .lpbk_en(lpbk_en),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .status_last(status_last), .csr_address(csr_address),
        .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] val(input int k);
        return (k < nstat) ? stat_vals[k] : stat_vals[nstat-1];
    endfunction

    // Advance one clock; the responder returns the scripted word one cycle after a read strobe.
    task automatic step();
        logic prev_read;
        prev_read = csr_read;
        @(posedge clk);
        #1;
        if (prev_read) begin
            csr_readdata = val(rd_idx);
            rd_idx++;
        end else begin
            csr_readdata = $urandom;
        end
    endtask

    task automatic ref_model(output int reads, output bit p, output bit to, output logic [31:0] last);
        reads = 64; p = 0; to = 0; last = 32'h0;
        for (int k = 0; k < 64; k++) begin
            logic [31:0] v;
            v = val(k);
            if ((v & MASK) == MASK) begin
                reads = k + 1; p = 1; to = 0; last = v;
                return;
            end
`ifdef LPBK_SEQ_TIMEOUT_EN
            if (k + 1 >= TPOLLS) begin
                reads = k + 1; p = 0; to = 1; last = v;
                return;
            end
`endif
        end
    endtask

    task automatic load_script(input int nfail, input logic [31:0] fail_v, input logic [31:0] pass_v);
        for (int k = 0; k < nfail; k++) stat_vals[k] = fail_v;
        stat_vals[nfail] = pass_v;
        nstat = nfail + 1;
    endtask

    // inject: offset at which to pulse start again (0 = never, -2 = on the done cycle)
    task automatic run_seq(input bit lp, input int inject, input int exp_reads,
                           input bit exp_pass, input bit exp_to, input logic [31:0] exp_last);
        int          wr_cnt, wr_off, rd_cnt, done_off, busy_bad, proto_bad, done_exp;
        logic [31:0] wr_data;
        logic [3:0]  wr_addr;
        wr_cnt = 0; wr_off = -1; rd_cnt = 0; done_off = -1; busy_bad = 0; proto_bad = 0;
        wr_data = 32'h0; wr_addr = 4'h0;
        rd_idx = 0;
        done_exp = 4 + (exp_reads - 1) * (2 + GAP);
        start = 1'b1; lpbk_en = lp;
        step();
        start = 1'b0; lpbk_en = ~lp;
        for (int off = 1; off <= 400 && done_off < 0; off++) begin
            if (csr_write) begin
                wr_cnt++;
                if (wr_cnt == 1) begin
                    wr_off = off; wr_data = csr_writedata; wr_addr = csr_address;
                end
            end
            if (csr_read) begin
                chk("rd_addr", 32'(csr_address), 32'(STAT));
                chk("rd_offset", off, 2 + rd_cnt * (2 + GAP));
                rd_cnt++;
            end
            if (csr_read && csr_write) proto_bad++;
            if (!csr_read && !csr_write && (csr_address != 4'h0 || csr_writedata != 32'h0)) proto_bad++;
            if (!busy) busy_bad++;
            if (done) begin
                done_off = off;
                chk("pass_at_done", 32'(pass), 32'(exp_pass));
                chk("timeout_at_done", 32'(timeout), 32'(exp_to));
                chk("status_last", status_last, exp_last);
            end
            if (off == inject || (inject == -2 && off == done_exp)) start = 1'b1;
            step();
            start = 1'b0;
        end
        chk("done_offset", done_off, done_exp);
        chk("write_count", wr_cnt, 1);
        chk("write_offset", wr_off, 1);
        chk("write_addr", 32'(wr_addr), 32'(CTRL));
        chk("write_data", wr_data, {31'b0, lp});
        chk("read_count", rd_cnt, exp_reads);
        chk("busy_gaps", busy_bad, 0);
        chk("bus_protocol", proto_bad, 0);
        chk("busy_after_done", 32'(busy), 32'h0);
        chk("pass_held", 32'(pass), 32'(exp_pass));
        chk("timeout_held", 32'(timeout), 32'(exp_to));
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; lpbk_en = 1'b0; csr_readdata = 32'h0;
        rd_idx = 0; nstat = 1; stat_vals[0] = 32'h3;

        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_pass", 32'(pass), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_strobes", {30'b0, csr_read, csr_write}, 32'h0);
        chk("rst_addr", 32'(csr_address), 32'h0);
        chk("rst_wdata", csr_writedata, 32'h0);
        chk("rst_status", status_last, 32'h0);

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        vecs[0] = '{lp:1, nfail:0, fail_v:32'h0, pass_v:32'h3, inject:0,
                    exp_reads:1, exp_pass:1, exp_to:0, exp_last:32'h3};
        vecs[1] = '{lp:1, nfail:3, fail_v:32'h1, pass_v:32'h3, inject:0,
                    exp_reads:4, exp_pass:1, exp_to:0, exp_last:32'h3};
        vecs[2] = '{lp:0, nfail:0, fail_v:32'h0, pass_v:32'hFFFF_FFFF, inject:2,
                    exp_reads:1, exp_pass:1, exp_to:0, exp_last:32'hFFFF_FFFF};
        vecs[3] = '{lp:1, nfail:2, fail_v:32'h2, pass_v:32'h7, inject:-2,
                    exp_reads:3, exp_pass:1, exp_to:0, exp_last:32'h7};
        vecs[4] = '{lp:0, nfail:1, fail_v:32'h0, pass_v:32'h3, inject:9,
                    exp_reads:2, exp_pass:1, exp_to:0, exp_last:32'h3};
        n_vec = 5;
`ifdef LPBK_SEQ_TIMEOUT_EN
        vecs[5] = '{lp:1, nfail:20, fail_v:32'h2, pass_v:32'h3, inject:0,
                    exp_reads:5, exp_pass:0, exp_to:1, exp_last:32'h2};
        n_vec = 6;
`endif
        for (int i = 0; i < n_vec; i++) begin
            load_script(vecs[i].nfail, vecs[i].fail_v, vecs[i].pass_v);
            run_seq(vecs[i].lp, vecs[i].inject, vecs[i].exp_reads,
                    vecs[i].exp_pass, vecs[i].exp_to, vecs[i].exp_last);
        end

        // Reset asserted between clock edges while the sequencer waits in GAP.
        stat_vals[0] = 32'h1; nstat = 1; rd_idx = 0;
        start = 1'b1; lpbk_en = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("pre_reset_busy", 32'(busy), 32'h1);
        chk("pre_reset_status", status_last, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_strobes", {30'b0, csr_read, csr_write}, 32'h0);
        chk("async_status", status_last, 32'h0);
        chk("async_addr", 32'(csr_address), 32'h0);
        chk("async_pass", 32'(pass), 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        step();
        chk("post_reset_idle", 32'(busy), 32'h0);
        load_script(0, 32'h0, 32'h3);
        run_seq(1'b1, 0, 1, 1'b1, 1'b0, 32'h3);

        // Randomized sequences against the reference model.
        for (int it = 0; it < 20; it++) begin
            int          nf, reads, inj;
            bit          p, to, lp;
            logic [31:0] last;
            nf = $urandom_range(0, 6);
            lp = 1'($urandom);
            for (int k = 0; k < nf; k++) begin
                logic [31:0] v;
                v = $urandom;
                if ((v & MASK) == MASK) v[1] = 1'b0;
                stat_vals[k] = v;
            end
            stat_vals[nf] = $urandom | MASK;
            nstat = nf + 1;
            ref_model(reads, p, to, last);
            inj = 0;
            if ($urandom_range(0, 1) == 1) inj = $urandom_range(1, 4 + (reads - 1) * (2 + GAP));
            run_seq(lp, inj, reads, p, to, last);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lpbk_csr_sequencer.md
# lpbk_csr_sequencer

- CSR initiator that drives the 4-bit-address / 32-bit-data control port of the native-PHY serial-loopback controller.
- On a start pulse it writes the loopback-enable control word, then polls the status word until the PLL-locked and CDR-locked-to-reference bits are both set.
- Reports pass/fail to the test-control logic.
- Sits between the QSFP test sequencer and the loopback controller's `csr_*` responder port.

## Interface
Parameters:
- `CTRL_ADDR`, 4'h0: CSR address of the control word; bit0 = serial loopback enable.
- `STAT_ADDR`, 4'h1: CSR address of the status word.
- `STAT_MASK`, 32'h3: status bits that must all read 1 (bit0 pll_locked, bit1 rx_is_lockedtoref).
- `POLL_GAP`, 16: idle cycles between consecutive status reads, range 1..65535.
- `TIMEOUT_POLLS`, 1000: failed status reads before declaring timeout, range 1..65535.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request; ignored while `busy`.
- `lpbk_en` in 1: loopback-enable value to write; sampled on accepted `start`.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `pass` out 1: last sequence met `STAT_MASK`; held until next accepted `start`.
- `timeout` out 1: last sequence exhausted `TIMEOUT_POLLS`; held until next accepted `start`.
- `status_last` out 32: last status word read.
- `csr_address` out 4: CSR address.
- `csr_read` out 1: CSR read strobe.
- `csr_write` out 1: CSR write strobe.
- `csr_writedata` out 32: CSR write data.
- `csr_readdata` in 32: CSR read data; fixed read latency 1.

## Operation
- CSR protocol: no waitrequest. A write completes in the cycle its strobe is high. Read data is valid exactly one cycle after the `csr_read` cycle. `csr_read` and `csr_write` are never high together. Each strobe lasts exactly one cycle.
- FSM states: IDLE, WRITE, READ, CAPTURE, GAP, FINISH.
  - IDLE: on `start`, latch `lpbk_en`, clear `pass`, `timeout` and the poll counter, then go to WRITE.
  - WRITE: drive `csr_write`=1, `csr_address`=`CTRL_ADDR`, `csr_writedata`={31'b0, latched lpbk_en}, then go to READ.
  - READ: drive `csr_read`=1, `csr_address`=`STAT_ADDR`, then go to CAPTURE.
  - CAPTURE: register `csr_readdata` into `status_last`.
    - If (`csr_readdata` & `STAT_MASK`) == `STAT_MASK`: set `pass`, go to FINISH.
    - Otherwise increment the poll counter and go to GAP.
  - GAP: count `POLL_GAP` cycles, then go to READ.
  - FINISH: `done`=1 for one cycle, then go to IDLE.
- `STAT_MASK`=0 passes on the first read.
- Poll counter is 16 bits and saturates; it never wraps.
- `start` while `busy` is dropped with no effect and no queuing.
- Outputs drive 0 on `csr_address` and `csr_writedata` when no strobe is active.

## Timing
- Reset values:
  - `busy`, `done`, `pass`, `timeout`, `csr_read`, `csr_write`: 0.
  - `csr_address`: 4'h0.
  - `csr_writedata`, `status_last`: 32'h0.
  - State: IDLE.
- `start` sampled at cycle T:
  - T+1: `busy`=1, `csr_write`=1.
  - T+2: `csr_read`=1.
  - T+3: CAPTURE.
  - Immediate pass: `done` at T+4, `busy`=0 at T+5.
- Each failed poll adds 2+`POLL_GAP` cycles, measured from one read strobe to the next.
- `busy` is high from the cycle after `start` through the FINISH cycle.
- `start` on the same cycle as the `done` pulse is ignored. `start` on the cycle after `done` is accepted.
- `reset_n` asserted mid-sequence: all outputs return to reset values immediately, including an in-flight strobe. The pending read data is discarded.

## Configuration
- Macro `LPBK_SEQ_TIMEOUT_EN`, defined:
  - In CAPTURE, a failed read when the poll counter reaches `TIMEOUT_POLLS` goes to FINISH with `timeout`=1 and `pass`=0.
- Macro not defined:
  - No timeout logic is built. The FSM polls indefinitely until the mask is met.
  - `timeout` is tied 0.

## Test plan
- `start`, `lpbk_en`=1, status reads 32'h3 -> write addr 0 data 32'h1 at T+1, read addr 1 at T+2, `done` and `pass`=1 at T+4, `status_last`=32'h3.
- Status reads 32'h1 for 3 polls then 32'h3, `POLL_GAP`=4 -> read strobes at T+2, T+8, T+14, T+20, `pass`=1 on the fourth read.
- `LPBK_SEQ_TIMEOUT_EN`, `TIMEOUT_POLLS`=5, status stuck 32'h2 -> exactly 5 reads, `done` with `timeout`=1, `pass`=0, `status_last`=32'h2.
- Second `start` pulsed while `busy` -> only one write observed, sequence unaffected.
- `reset_n` low during GAP -> `busy`, strobes and `status_last` return to 0 asynchronously. A later `start` runs a fresh sequence from WRITE.
